// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter: core writeback has priority, photon writes
// wait in an in-order queue with WAW kill, RAW detection and forced drain on starvation.
module regfile_wr_arbiter #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        Rst,
  input  logic        core_wr_en,
  input  logic [4:0]  core_wr_rd,
  input  logic [31:0] core_wr_data,
  input  logic        ph_req_valid,
  input  logic [4:0]  ph_req_rd,
  input  logic [31:0] ph_req_data,
  output logic        ph_req_ready,
  input  logic [4:0]  rd_rs1,
  input  logic [4:0]  rd_rs2,
  output logic        raw_stall,
  output logic        core_stall,
  output logic        rf_wen,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned AW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [AW-1:0] MAX_C   = AW'(MAX_WAIT);

  typedef enum logic [1:0] {IDLE, PEND, FORCE} state_t;

  logic [DEPTH-1:0] live_q, live_d;
  logic [4:0]       rd_q   [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [PW-1:0]    head_q, tail_q;
  logic [CW-1:0]    count_q, count_d;
  logic [AW-1:0]    age_q, age_d;
  state_t           state_q;
  logic             core_stall_q;

  logic core_win, not_empty, head_live, pop, ready_int, enq, hit;

  assign core_win  = core_wr_en && (core_wr_rd != '0);
  assign not_empty = (count_q != '0);
  assign head_live = not_empty && live_q[head_q];
  // A dead head is discarded regardless of who owns the port.
  assign pop       = not_empty && (!head_live || !core_win);
  assign ready_int = (count_q < DEPTH_C);
  assign enq       = ph_req_valid && ready_int;

  always_comb begin
    live_d = live_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (core_win && (rd_q[i] == core_wr_rd)) live_d[PW'(i)] = 1'b0;
    end
    if (pop) live_d[head_q] = 1'b0;
    // Applied after the kill so a same-cycle request survives as the newer write.
    if (enq) live_d[tail_q] = (ph_req_rd != '0);
  end

  always_comb begin
    count_d = count_q;
    if (enq && !pop)      count_d = count_q + CW'(1);
    else if (!enq && pop) count_d = count_q - CW'(1);
  end

  always_comb begin
    age_d = age_q;
    if (pop || !not_empty)              age_d = '0;
    else if (head_live && age_q < MAX_C) age_d = age_q + AW'(1);
  end

  always_comb begin
    hit = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (live_q[i] && (((rd_q[i] == rd_rs1) && (rd_rs1 != '0)) ||
                        ((rd_q[i] == rd_rs2) && (rd_rs2 != '0))))
        hit = 1'b1;
    end
  end

  always_comb begin
    rf_wen   = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (Rst) begin
      if (core_win) begin
        rf_wen   = 1'b1;
        rf_waddr = core_wr_rd;
        rf_wdata = core_wr_data;
      end else if (head_live) begin
        rf_wen   = 1'b1;
        rf_waddr = rd_q[head_q];
        rf_wdata = data_q[head_q];
      end
    end
  end

  assign raw_stall    = Rst && hit;
  assign ph_req_ready = Rst && ready_int;
  assign core_stall   = core_stall_q;

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      live_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      age_q   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else begin
      live_q  <= live_d;
      count_q <= count_d;
      age_q   <= age_d;
      if (pop) head_q <= head_q + PW'(1);
      if (enq) begin
        tail_q         <= tail_q + PW'(1);
        rd_q[tail_q]   <= ph_req_rd;
        data_q[tail_q] <= ph_req_data;
      end
    end
  end

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      state_q      <= IDLE;
      core_stall_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (enq) state_q <= PEND;
        PEND: begin
          if (count_d == '0) state_q <= IDLE;
          else if (!pop && age_q == MAX_C) begin
            state_q      <= FORCE;
            core_stall_q <= 1'b1;
          end
        end
        FORCE: begin
          if (pop) begin
            state_q      <= (count_d == '0) ? IDLE : PEND;
            core_stall_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= IDLE;
          core_stall_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
